fetch_unit: RTL
===============

# fetch_unit

- Instruction-issue side of the 8-bit CPU: fetches 16-bit instruction words from program memory, splits them into `opcode`/`reg1`/`reg2`/`reg3`, and presents them, held stable, to `ctrl_unit`.
- Owns the program counter and resolves jumps (JMP/JZ/JC) using the status register `sreg1`.
- Stops fetching on HLT.
- Sits between program memory and `ctrl_unit`; it produces the fields `ctrl_unit` decodes.

## Interface
Parameters:
- `RESET_PC`, default 8'h00: PC value loaded on reset.
- `ZERO_BIT`, default 0: bit of `sreg1` tested by JZ.
- `CARRY_BIT`, default 1: bit of `sreg1` tested by JC.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_addr` out 8: program memory address.
- `imem_rd` out 1: read strobe; data is valid on `imem_data` one cycle later.
- `imem_data` in 16: instruction word, laid out {opcode[15:12], reg1[11:8], reg2[7:4], reg3[3:0]}.
- `sreg1` in 8: status register from the register bank.
- `stall` in 1: downstream not ready; holds the current instruction.
- `opcode` out 4: registered field.
- `reg1`, `reg2`, `reg3` out 4 each: registered fields.
- `instr_valid` out 1: fields hold a live instruction this cycle.
- `pc` out 8: address of the instruction currently issued.
- `halted` out 1: HLT retired; fetching stopped.

## Operation
- States: FETCH, WAIT, ISSUE, HALT.
- FETCH:
  - `imem_addr`=`pc`, `imem_rd`=1.
  - Next state: WAIT.
- WAIT:
  - `imem_rd`=0.
  - At the closing edge, the instruction register captures `imem_data`.
  - Next state: ISSUE.
- ISSUE:
  - `instr_valid`=1; fields driven from the instruction register.
  - At the closing edge with `stall`=0:
    - `pc` ← next PC.
    - Next state: HALT if `opcode`=4'b1101, otherwise FETCH.
  - At the closing edge with `stall`=1: remain in ISSUE; fields and `instr_valid` held unchanged.
- HALT:
  - `imem_rd`=0, `instr_valid`=0, `halted`=1.
  - Fields keep the HLT word; `pc` keeps the HLT address.
  - Left only by reset.
- Next-PC rules (target = {reg2,reg3}):
  - 4'b1000 JMP: target.
  - 4'b1001 JZ: target if `sreg1[ZERO_BIT]`, else `pc`+1.
  - 4'b1010 JC: target if `sreg1[CARRY_BIT]`, else `pc`+1.
  - All other opcodes: `pc`+1.
  - 8-bit wrap: 8'hFF+1 = 8'h00.
- Branch condition sampling:
  - `sreg1` is sampled only at the ISSUE edge that retires the instruction.
  - If stalled, the last ISSUE cycle is the one that counts.
- Jump target equal to `pc` is legal (tight loop); no special case.
- No instruction is decoded other than jumps and HLT; all other opcodes pass through unmodified.

## Timing
- Reset (`rst_n`=0, asynchronous) forces immediately:
  - state FETCH, `pc`=`RESET_PC`.
  - `opcode`/`reg1`/`reg2`/`reg3`=0, instruction register = 0.
  - `instr_valid`=0, `halted`=0.
  - `imem_rd`=1, `imem_addr`=`RESET_PC` (decoded from state).
- Reset release is synchronous in effect: the first edge with `rst_n`=1 leaves FETCH.
- Reset mid-ISSUE or mid-HALT aborts the instruction; no PC update.
- Throughput: 3 cycles per instruction with no stall; each stall cycle adds 1.
- Reset-release to first `instr_valid`: 2 edges (FETCH, WAIT), then ISSUE.
- `instr_valid` is a one-cycle pulse per instruction when `stall`=0.
- Fields change only on entry to ISSUE, so `ctrl_unit` sees stable values for the whole ISSUE window plus the following FETCH/WAIT.
- `imem_addr` is valid only while `imem_rd`=1.
- `halted` rises on the edge that retires HLT.
- `stall` is ignored outside ISSUE.

## Test plan
- **Sequential run:** memory words 0..2 = 16'h0123, 16'h4567, 16'h1111, `stall`=0 → `instr_valid` pulses every 3rd cycle; `pc` 0,1,2; fields 0/1/2/3 then 4/5/6/7.
- **Jumps:** JMP 16'h8042 at address 0 → next fetch at address 8'h42. JZ 16'h9010 with `sreg1`=8'h01 → `pc`=8'h10; same instruction with `sreg1`=8'h00 → `pc`=1. JC 16'hA0F0 with `sreg1`=8'h02 → `pc`=8'hF0.
- **Wrap-around:** `RESET_PC`=8'hFF, non-jump word → second fetch at address 8'h00.
- **Stall:** `stall`=1 for 4 cycles during ISSUE of a JZ, `sreg1` toggled each cycle → `instr_valid` held 5 cycles, fields stable, branch follows the `sreg1` value in the final cycle.
- **Halt:** HLT 16'hD000 at address 3 → `halted`=1 one edge after its ISSUE; `imem_rd` stays 0 for 20 cycles; `pc`=3.
- **Async reset:** `rst_n` dropped mid-WAIT, mid-ISSUE and in HALT, asynchronously between edges → outputs reach reset values without waiting for a clock edge; after release the first fetch address is `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch for the 8-bit CPU: owns the PC, fetches 16-bit words,
// holds the split fields stable for ctrl_unit and resolves JMP/JZ/JC/HLT.
module fetch_unit #(
    parameter logic [7:0] RESET_PC  = 8'h00,
    parameter int         ZERO_BIT  = 0,
    parameter int         CARRY_BIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [7:0]  imem_addr,
    output logic        imem_rd,
    input  logic [15:0] imem_data,
    input  logic [7:0]  sreg1,
    input  logic        stall,
    output logic [3:0]  opcode,
    output logic [3:0]  reg1,
    output logic [3:0]  reg2,
    output logic [3:0]  reg3,
    output logic        instr_valid,
    output logic [7:0]  pc,
    output logic        halted
);

    // state   | meaning
    // S_FETCH | read strobe out, imem_addr = pc
    // S_WAIT  | memory returns word; instruction register loads at edge
    // S_ISSUE | fields valid to ctrl_unit; retire when stall = 0
    // S_HALT  | HLT retired, fetching stopped until reset
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [3:0] OP_JMP = 4'b1000;
    localparam logic [3:0] OP_JZ  = 4'b1001;
    localparam logic [3:0] OP_JC  = 4'b1010;
    localparam logic [3:0] OP_HLT = 4'b1101;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [7:0]  pc_inc, target, npc;
    logic        zero_flag, carry_flag;

    // Mask-and-reduce keeps every sreg1 bit in the logic cone.
    assign zero_flag  = |(sreg1 & (8'd1 << ZERO_BIT));
    assign carry_flag = |(sreg1 & (8'd1 << CARRY_BIT));
    assign pc_inc     = pc_q + 8'd1;
    assign target     = ir_q[7:0];

    always_comb begin
        npc = pc_inc;
        case (ir_q[15:12])
            OP_JMP:  npc = target;
            OP_JZ:   npc = zero_flag  ? target : pc_inc;
            OP_JC:   npc = carry_flag ? target : pc_inc;
            default: npc = pc_inc;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                ir_d    = imem_data;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (!stall) begin
                    // HLT keeps its own address in pc for the debugger.
                    if (ir_q[15:12] == OP_HLT) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d    = npc;
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign imem_rd     = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == S_ISSUE);
    assign halted      = (state_q == S_HALT);
    assign pc          = pc_q;
    assign opcode      = ir_q[15:12];
    assign reg1        = ir_q[11:8];
    assign reg2        = ir_q[7:4];
    assign reg3        = ir_q[3:0];

endmodule
